// File: rtl/flash_therm_sampler.sv
// Flash ADC front end: 2-flop comparator sync, divided sample strobe,
// bubble correction (majority + prefix fill), capture and debug counter.
//
// Ports:
//   clk, rst_n    clock, async active-low reset
//   en            sampling enable; low holds the divider at 0
//   comp_in[6:0]  raw comparator outputs, bit k = Vin > Vref(k+1)
//   clr_cnt       synchronous clear of bubble_cnt (wins over increment)
//   therm_out     corrected thermometer code, bit 0 always 0
//   therm_valid   one-cycle pulse after each capture
//   bubble_flag   last captured sample needed correction
//   bubble_cnt    saturating count of corrected samples
module flash_therm_sampler #(
  parameter int SAMPLE_DIV = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [6:0]       comp_in,
  input  logic             clr_cnt,
  output logic [7:0]       therm_out,
  output logic             therm_valid,
  output logic             bubble_flag,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam int DW =
    (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST =
    DW'(SAMPLE_DIV - 1);

  logic [6:0]    s1;
  logic [6:0]    s2;
  logic [DW-1:0] div_cnt;
  logic          strobe;
  logic [8:0]    ext;
  logic [6:0]    maj_v;
  logic [6:0]    fill;
  logic          acc;
  logic          bubble;

  // Synchroniser runs regardless of en so that
  // the first strobe after enable sees settled data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= comp_in;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (!en || div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign strobe = en && (div_cnt == DIV_LAST);

  // ext[k+1] = c_k, with c(-1) = 1 below and c7 = 0 above.
  // The running AND keeps the prefix fill free of
  // self-referencing combinational vectors.
  always_comb begin
    ext   = {1'b0, s2, 1'b1};
    maj_v = '0;
    fill  = '0;
    acc   = 1'b1;
    for (int k = 0; k < 7; k++) begin
      maj_v[k] = (ext[k]   & ext[k+1])
               | (ext[k]   & ext[k+2])
               | (ext[k+1] & ext[k+2]);
      acc      = acc & maj_v[k];
      fill[k]  = acc;
    end
  end

  assign bubble = (fill != s2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      therm_out   <= '0;
      bubble_flag <= 1'b0;
      therm_valid <= 1'b0;
    end else begin
      therm_valid <= strobe;
      if (strobe) begin
        therm_out   <= {fill, 1'b0};
        bubble_flag <= bubble;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else if (clr_cnt) begin
      bubble_cnt <= '0;
    end else if (strobe && bubble
                 && bubble_cnt != '1) begin
      bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_flash_therm_sampler.sv
// Directed bench for flash_therm_sampler.
// Main DUT at SAMPLE_DIV=4/CNT_W=8, second at 1/2.
module tb_flash_therm_sampler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       clr_cnt = 1'b0;
  logic [6:0] comp_in = '0;
  logic [7:0] therm_out;
  logic       therm_valid;
  logic       bubble_flag;
  logic [7:0] bubble_cnt;

  logic       en2 = 1'b0;
  logic       clr2 = 1'b0;
  logic [6:0] comp2 = '0;
  logic [7:0] therm2;
  logic       valid2;
  logic       flag2;
  logic [1:0] cnt2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  flash_therm_sampler #(
    .SAMPLE_DIV(4),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .comp_in(comp_in),
    .clr_cnt(clr_cnt),
    .therm_out(therm_out),
    .therm_valid(therm_valid),
    .bubble_flag(bubble_flag),
    .bubble_cnt(bubble_cnt)
  );

  flash_therm_sampler #(
    .SAMPLE_DIV(1),
    .CNT_W(2)
  ) dut2 (
    .clk(clk),
    .rst_n(rst_n),
    .en(en2),
    .comp_in(comp2),
    .clr_cnt(clr2),
    .therm_out(therm2),
    .therm_valid(valid2),
    .bubble_flag(flag2),
    .bubble_cnt(cnt2)
  );

  task automatic wait_valid(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (therm_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: therm_valid got none want pulse", tag);
    end
  endtask

  // Second pulse after a change always reflects the new input.
  task automatic settle(input logic [6:0] v, input string tag);
    comp_in = v;
    wait_valid(tag);
    wait_valid(tag);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({therm_out, therm_valid, bubble_flag, bubble_cnt} !== 18'd0) begin
      errors++;
      $display("FAIL reset: got %h/%b/%b/%h want 0", therm_out,
               therm_valid, bubble_flag, bubble_cnt);
    end
    checks++;
    if ({therm2, valid2, flag2, cnt2} !== 12'd0) begin
      errors++;
      $display("FAIL reset2: got %h/%b/%b/%h want 0", therm2,
               valid2, flag2, cnt2);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_nominal;
    int n;
    en = 1'b1;
    settle(7'b0001111, "nominal");
    checks++;
    if (therm_out !== 8'b00011110) begin
      errors++;
      $display("FAIL nominal therm: got %b want 00011110", therm_out);
    end
    checks++;
    if (bubble_flag !== 1'b0 || bubble_cnt !== 8'd0) begin
      errors++;
      $display("FAIL nominal flag/cnt: got %b/%0d want 0/0",
               bubble_flag, bubble_cnt);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (therm_valid !== 1'b1 && n < 20);
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL valid period: got %0d want 4", n);
    end
  endtask

  task automatic test_low_bubble;
    logic [7:0] c0;
    settle(7'b0001011, "low");
    checks++;
    if (therm_out !== 8'b00001110 || bubble_flag !== 1'b1) begin
      errors++;
      $display("FAIL low bubble: got %b/%b want 00001110/1",
               therm_out, bubble_flag);
    end
    c0 = bubble_cnt;
    wait_valid("low+1");
    checks++;
    if (bubble_cnt !== c0 + 8'd1) begin
      errors++;
      $display("FAIL low cnt+1: got %0d want %0d", bubble_cnt, c0 + 1);
    end
    wait_valid("low+2");
    checks++;
    if (bubble_cnt !== c0 + 8'd2) begin
      errors++;
      $display("FAIL low cnt+2: got %0d want %0d", bubble_cnt, c0 + 2);
    end
  endtask

  task automatic test_high_bubble;
    settle(7'b0100011, "high");
    checks++;
    if (therm_out !== 8'b00000110 || bubble_flag !== 1'b1) begin
      errors++;
      $display("FAIL high bubble: got %b/%b want 00000110/1",
               therm_out, bubble_flag);
    end
    settle(7'b1100100, "double");
    checks++;
    if (therm_out !== 8'b00000000 || bubble_flag !== 1'b1) begin
      errors++;
      $display("FAIL double fault: got %b/%b want 00000000/1",
               therm_out, bubble_flag);
    end
  endtask

  task automatic test_sweep;
    logic [6:0] codes [8];
    logic [7:0] want  [8];
    codes = '{7'b0000000, 7'b0000001, 7'b0000011, 7'b0000111,
              7'b0001111, 7'b0011111, 7'b0111111, 7'b1111111};
    want  = '{8'b00000000, 8'b00000010, 8'b00000110, 8'b00001110,
              8'b00011110, 8'b00111110, 8'b01111110, 8'b11111110};
    for (int n = 0; n < 8; n++) begin
      settle(codes[n], "sweep");
      checks++;
      if (therm_out !== want[n] || bubble_flag !== 1'b0) begin
        errors++;
        $display("FAIL sweep %0d: got %b/%b want %b/0", n,
                 therm_out, bubble_flag, want[n]);
      end
      checks++;
      if ($countones(therm_out) !== n) begin
        errors++;
        $display("FAIL encode %0d: got %0d want %0d", n,
                 $countones(therm_out), n);
      end
    end
  endtask

  task automatic test_counter;
    en2 = 1'b0;
    comp2 = 7'b0001011;
    repeat (3) @(negedge clk);
    en2 = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (cnt2 !== 2'd2 || flag2 !== 1'b1 || valid2 !== 1'b1
        || therm2 !== 8'b00001110) begin
      errors++;
      $display("FAIL cnt2 two: got %0d/%b/%b/%b want 2/1/1/00001110",
               cnt2, flag2, valid2, therm2);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (cnt2 !== 2'd3) begin
      errors++;
      $display("FAIL cnt2 sat: got %0d want 3", cnt2);
    end
    clr2 = 1'b1;
    @(negedge clk);
    checks++;
    if (cnt2 !== 2'd0) begin
      errors++;
      $display("FAIL cnt2 clr: got %0d want 0", cnt2);
    end
    clr2 = 1'b0;
    @(negedge clk);
    checks++;
    if (cnt2 !== 2'd1) begin
      errors++;
      $display("FAIL cnt2 after clr: got %0d want 1", cnt2);
    end
    en2 = 1'b0;
  endtask

  task automatic test_en_low;
    logic [7:0] held;
    int seen;
    wait_valid("enlow");
    en = 1'b0;
    held = therm_out;
    comp_in = 7'b0111111;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (therm_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL en low valid: got %0d pulses want 0", seen);
    end
    checks++;
    if (therm_out !== held) begin
      errors++;
      $display("FAIL en low hold: got %b want %b", therm_out, held);
    end
    en = 1'b1;
  endtask

  task automatic test_reset_mid;
    int seen;
    settle(7'b0001011, "mid");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({therm_out, therm_valid, bubble_flag, bubble_cnt} !== 18'd0) begin
      errors++;
      $display("FAIL mid reset: got %h/%b/%b/%h want 0", therm_out,
               therm_valid, bubble_flag, bubble_cnt);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (therm_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0 || therm_out !== 8'd0) begin
      errors++;
      $display("FAIL stale valid: got %0d/%b want 0/00000000",
               seen, therm_out);
    end
    wait_valid("post reset");
    checks++;
    if (therm_out !== 8'b00001110 || bubble_flag !== 1'b1
        || bubble_cnt !== 8'd1) begin
      errors++;
      $display("FAIL post reset: got %b/%b/%0d want 00001110/1/1",
               therm_out, bubble_flag, bubble_cnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_nominal();
    test_low_bubble();
    test_high_bubble();
    test_sweep();
    test_counter();
    test_en_low();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
